// File: rtl/hello_letter_scheduler.sv
// hello_letter_scheduler
// Two-way round-robin arbiter and letter sequencer for a synchronous-read
// letter memory. The winning requester's message (base, len) is walked one
// letter at a time; each letter is offered on a valid/ready output.
//
// Handshake: a letter transfers on any rising edge where valid and ready are
// both high. Once valid is raised, letter and valid are held unchanged until
// that transfer happens. The consumer may drive ready freely.
//
// All outputs come straight from flops. The next value of every flop is
// computed in one always_comb block (<sig>_d) and registered in one
// always_ff block (<sig>_q).

module hello_letter_scheduler #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        letter,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Sequencer state
  state_t              state_q,    state_d;
  logic                last_q,     last_d;     // requester granted most recently
  logic                owner_q,    owner_d;    // requester owning the message
  logic [ADDR_W-1:0]   ptr_q,      ptr_d;      // address of the next letter
  logic [LEN_W-1:0]    len_q,      len_d;      // latched message length
  logic [LEN_W-1:0]    count_q,    count_d;    // letters handed over so far

  // Registered outputs
  logic                gnt0_q,     gnt0_d;
  logic                gnt1_q,     gnt1_d;
  logic                mem_en_q,   mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          letter_q,   letter_d;
  logic                valid_q,    valid_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                done_id_q,  done_id_d;

  // Arbitration: a lone requester wins; with both asking, the one not
  // granted last time wins.
  logic                win;
  logic [ADDR_W-1:0]   win_base;
  logic [LEN_W-1:0]    win_len;
  logic [ADDR_W-1:0]   ptr_inc;
  logic [LEN_W-1:0]    count_inc;

  assign win       = (req0 && req1) ? ~last_q : req1;
  assign win_base  = win ? base1 : base0;
  assign win_len   = win ? len1  : len0;
  assign ptr_inc   = ptr_q + ADDR_W'(1);
  assign count_inc = count_q + LEN_W'(1);

  // Next-state and next-output logic for the whole sequencer
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    count_d    = count_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    letter_d   = letter_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          last_d  = win;
          ptr_d   = win_base;
          len_d   = win_len;
          count_d = '0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          busy_d  = 1'b1;
          if (win_len != '0) begin
            // The first read is issued together with the grant.
            state_d    = S_READ;
            mem_en_d   = 1'b1;
            mem_addr_d = win_base;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_READ: begin
        // Memory samples mem_en/mem_addr on this edge; data arrives in LOAD.
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (mem_data == 8'h00) begin
          // Terminator ends the message early and is never emitted.
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end else begin
          letter_d = mem_data;
          valid_d  = 1'b1;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        if (ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_inc;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_id_d = owner_q;
          end else begin
            state_d    = S_READ;
            mem_en_d   = 1'b1;
            mem_addr_d = ptr_inc;
          end
        end
      end

      S_DONE: begin
        if (done_q) begin
          // done has been shown for its one cycle; release the block.
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Entered straight from a zero-length grant: show done next cycle.
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes effect immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      ptr_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      letter_q   <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      letter_q   <= letter_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign letter    = letter_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hello_letter_scheduler.sv
// Testbench for hello_letter_scheduler: directed scenarios plus randomized
// messages, checked by a scoreboard fed from a message-level reference model.

module tb_hello_letter_scheduler;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] base0 = 8'h00, base1 = 8'h00;
  logic [7:0] len0 = 8'h00, len1 = 8'h00;
  logic       gnt0, gnt1, mem_en, valid, busy, done, done_id;
  logic [7:0] mem_addr, letter;
  logic [7:0] mem_data = 8'h00;
  logic       ready = 1'b1;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  hello_letter_scheduler #(.ADDR_W(8), .LEN_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1),
    .base0(base0), .base1(base1),
    .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .letter(letter), .valid(valid), .ready(ready),
    .busy(busy), .done(done), .done_id(done_id),
    .dbg_state(dbg_state)
  );

  // Synchronous-read letter memory: data valid the cycle after mem_en
  logic [7:0] mem [256];
  always @(posedge CLK) if (mem_en) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct { logic [7:0] ch; int off; bit timed; } let_t;
  typedef struct { logic id; int off; bit timed; } done_t;

  logic [7:0] exp_addr_q[$];
  let_t       exp_let_q[$];
  done_t      exp_done_q[$];
  logic       exp_gnt_q[$];

  int   checks = 0;
  int   errors = 0;
  int   rmode = 0;       // 0: ready high, 1: random, 2: stall second letter
  int   stall_cnt = 0;
  int   hs_in_msg = 0;
  int   g_cyc = 0;
  bit   in_msg = 0;
  logic model_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: what one granted message must produce, derived from
  // memory contents. Offsets are cycles after the grant with ready held high.
  task automatic predict_msg(input logic id, input logic [7:0] base, input logic [7:0] len,
                             input bit timed);
    logic [7:0] a;
    int         k;
    bit         term;
    int         doff;
    a = base;
    k = 0;
    term = 0;
    exp_gnt_q.push_back(id);
    for (int i = 0; i < int'(len); i++) begin
      exp_addr_q.push_back(a);
      if (mem[a] == 8'h00) begin
        term = 1;
        break;
      end
      exp_let_q.push_back('{mem[a], 2 + 3 * k, timed});
      k++;
      a = a + 8'd1;
    end
    if (len == 8'd0) doff = 1;
    else if (term)   doff = 2 + 3 * k;
    else             doff = 3 * k;
    exp_done_q.push_back('{id, doff, timed});
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (gnt0 || gnt1) begin
        if (exp_gnt_q.size() == 0) fail_now("unexpected_gnt");
        else begin
          logic gid;
          gid = exp_gnt_q.pop_front();
          check("gnt_onehot", 32'({gnt1, gnt0}), gid ? 32'd2 : 32'd1);
        end
        g_cyc = cyc;
        hs_in_msg = 0;
        in_msg = 1;
      end
      check("busy", 32'(busy), 32'(in_msg));
      if (mem_en) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_mem_read");
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (valid) begin
        check("no_read_while_valid", 32'(mem_en), 32'd0);
        if (exp_let_q.size() == 0) fail_now("unexpected_letter");
        else begin
          check("letter", 32'(letter), 32'(exp_let_q[0].ch));
          if (ready) begin
            let_t e;
            e = exp_let_q.pop_front();
            if (e.timed) check("letter_cycle", 32'(cyc - g_cyc), 32'(e.off));
            hs_in_msg++;
          end
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) fail_now("unexpected_done");
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("done_id", 32'(done_id), 32'(d.id));
          if (d.timed) check("done_cycle", 32'(cyc - g_cyc), 32'(d.off));
        end
        in_msg = 0;
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (rmode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: begin
          if (valid && hs_in_msg == 1 && stall_cnt < 7) begin
            ready = 1'b0;
            stall_cnt++;
          end else begin
            ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(output int who, output bit ok);
    ok = 0;
    who = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Raise the given requests, predict the grant order, and serve each one.
  task automatic serve(input bit r0, input bit r1,
                       input logic [7:0] b0, input logic [7:0] l0,
                       input logic [7:0] b1, input logic [7:0] l1, input int rm);
    logic first;
    int   who;
    bit   ok;
    int   n;
    rmode = rm;
    stall_cnt = 0;
    first = (r0 && r1) ? ~model_last : r1;
    predict_msg(first, first ? b1 : b0, first ? l1 : l0, rm == 0);
    if (r0 && r1) begin
      predict_msg(~first, first ? b0 : b1, first ? l0 : l1, rm == 0);
      model_last = ~first;
    end else begin
      model_last = first;
    end
    @(posedge CLK);
    #1;
    req0 = r0; req1 = r1;
    base0 = b0; len0 = l0; base1 = b1; len1 = l1;
    n = (r0 && r1) ? 2 : 1;
    for (int m = 0; m < n; m++) begin
      wait_gnt(who, ok);
      if (!ok) begin
        fail_now("gnt_timeout");
        break;
      end
      @(posedge CLK);
      #1;
      // Drop the served request and scramble its inputs: they were latched.
      if (who == 1) begin
        req1 = 0; base1 = 8'($urandom); len1 = 8'($urandom);
      end else begin
        req0 = 0; base0 = 8'($urandom); len0 = 8'($urandom);
      end
      wait_done(ok);
      if (!ok) begin
        fail_now("done_timeout");
        break;
      end
    end
    req0 = 0;
    req1 = 0;
    repeat (2) @(posedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   who;
    bit   ok;
    logic [7:0] hello [6];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 6; i++) mem[8'h10 + i] = hello[i];
    mem[8'hFE] = 8'h61; mem[8'hFF] = 8'h62; mem[8'h00] = 8'h63; mem[8'h01] = 8'h64;
    mem[8'h20] = 8'h57; mem[8'h21] = 8'h4F; mem[8'h22] = 8'h52;

    // Reset state
    #1 RST = 1'b1;
    @(negedge CLK);
    check("reset_outputs",
          32'({letter, valid, mem_en, mem_addr, gnt0, gnt1, busy, done, done_id}), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // HELLO, exact length, and terminator stop
    serve(1, 0, 8'h10, 8'd5, 8'h00, 8'd0, 0);
    serve(1, 0, 8'h10, 8'd10, 8'h00, 8'd0, 0);
    // Both requesting: alternation, then req1 alone
    serve(1, 1, 8'h10, 8'd5, 8'h20, 8'd3, 0);
    serve(1, 1, 8'h20, 8'd3, 8'h10, 8'd4, 0);
    serve(0, 1, 8'h00, 8'd0, 8'h10, 8'd2, 0);
    serve(0, 1, 8'h00, 8'd0, 8'h20, 8'd3, 0);
    // Backpressure on the second letter
    serve(1, 0, 8'h10, 8'd5, 8'h00, 8'd0, 2);
    // Address wrap and zero length
    serve(0, 1, 8'h00, 8'd0, 8'hFE, 8'd4, 0);
    serve(1, 0, 8'h10, 8'd0, 8'h00, 8'd0, 0);

    // Reset in the middle of a letter transfer
    rmode = 0;
    predict_msg(1'b0, 8'h10, 8'd5, 1);
    model_last = 1'b0;
    @(posedge CLK);
    #1 req0 = 1; base0 = 8'h10; len0 = 8'd5;
    wait_gnt(who, ok);
    if (!ok) fail_now("gnt_timeout_rst");
    @(posedge CLK);
    #1 req0 = 0; req1 = 1; base1 = 8'h20; len1 = 8'd3;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("valid_timeout_rst");
    #2 RST = 1'b1;
    #1 check("async_reset_outputs",
             32'({letter, valid, mem_en, mem_addr, gnt0, gnt1, busy, done, done_id}), 32'd0);
    exp_addr_q.delete(); exp_let_q.delete(); exp_done_q.delete(); exp_gnt_q.delete();
    model_last = 1'b1;
    in_msg = 0;
    req0 = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    serve(1, 1, 8'h10, 8'd5, 8'h20, 8'd3, 0);

    // Randomized messages over random memory contents
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int t = 0; t < 30; t++) begin
      int r;
      r = $urandom_range(1, 3);
      serve(r[0], r[1], 8'($urandom), 8'($urandom_range(0, 12)),
            8'($urandom), 8'($urandom_range(0, 12)), $urandom_range(0, 1));
    end

    repeat (4) @(posedge CLK);
    check("gnt_q_drained", 32'(exp_gnt_q.size()), 32'd0);
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("letter_q_drained", 32'(exp_let_q.size()), 32'd0);
    check("done_q_drained", 32'(exp_done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
